// File: rtl/elevator_scheduler.sv
// elevator_scheduler: latches call buttons and sweeps a one-hot car
// position floor by floor in SCAN order, dwelling with the door open
// at every served floor.
//
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset
//   req_in[7:0]  call buttons, bit i = floor i+1 (level or pulse)
//   cur_floor    one-hot current floor, bit 0 = floor 1
//   pending      latched requests not yet served
//   moving_up    high while travelling up
//   moving_down  high while travelling down
//   door_open    high while the door dwell runs
//   arrive       one-cycle pulse on the cycle the door opens
module elevator_scheduler #(
    parameter int unsigned STEP_CYCLES = 16777216,
    parameter int unsigned DOOR_CYCLES = 33554432
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req_in,
    output logic [7:0] cur_floor,
    output logic [7:0] pending,
    output logic       moving_up,
    output logic       moving_down,
    output logic       door_open,
    output logic       arrive
);

    typedef enum logic [1:0] {
        IDLE,
        MOVE_UP,
        MOVE_DOWN,
        DOOR
    } state_t;

    localparam int unsigned MAXC =
        (STEP_CYCLES > DOOR_CYCLES) ? STEP_CYCLES : DOOR_CYCLES;
    localparam int TW = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [TW-1:0] STEP_LAST = TW'(STEP_CYCLES - 1);
    localparam logic [TW-1:0] DOOR_LAST = TW'(DOOR_CYCLES - 1);

    state_t        state;
    state_t        state_n;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_n;
    logic          dir_up;
    logic          dir_n;
    logic [7:0]    cur_n;
    logic [7:0]    pend_n;
    logic [7:0]    clear;
    logic          arrive_n;

    logic [7:0]    lower_mask;
    logic [7:0]    upper_mask;
    logic [7:0]    up_floor;
    logic [7:0]    dn_floor;
    logic          above;
    logic          below;
    logic          step_done;
    logic          door_done;

    // cur_floor is one-hot, so subtracting one yields every lower floor.
    assign lower_mask = cur_floor - 8'd1;
    assign upper_mask = ~(cur_floor | lower_mask);
    assign above      = |(pending & upper_mask);
    assign below      = |(pending & lower_mask);
    assign up_floor   = {cur_floor[6:0], 1'b0};
    assign dn_floor   = {1'b0, cur_floor[7:1]};
    assign step_done  = (timer == STEP_LAST);
    assign door_done  = (timer == DOOR_LAST);

    always_comb begin
        state_n  = state;
        cur_n    = cur_floor;
        timer_n  = timer;
        dir_n    = dir_up;
        clear    = '0;
        arrive_n = 1'b0;

        unique case (state)
            IDLE: begin
                timer_n = '0;
                if (|(pending & cur_floor)) begin
                    // Call at the floor the car already sits on.
                    state_n  = DOOR;
                    clear    = cur_floor;
                    arrive_n = 1'b1;
                    dir_n    = 1'b1;
                end else if (above) begin
                    state_n = MOVE_UP;
                    dir_n   = 1'b1;
                end else if (below) begin
                    state_n = MOVE_DOWN;
                    dir_n   = 1'b0;
                end
            end

            MOVE_UP: begin
                if (step_done) begin
                    cur_n   = up_floor;
                    timer_n = '0;
                    if (|(pending & up_floor)) begin
                        state_n  = DOOR;
                        clear    = up_floor;
                        arrive_n = 1'b1;
                    end
                end else begin
                    timer_n = timer + 1'b1;
                end
            end

            MOVE_DOWN: begin
                if (step_done) begin
                    cur_n   = dn_floor;
                    timer_n = '0;
                    if (|(pending & dn_floor)) begin
                        state_n  = DOOR;
                        clear    = dn_floor;
                        arrive_n = 1'b1;
                    end
                end else begin
                    timer_n = timer + 1'b1;
                end
            end

            DOOR: begin
                // Presses for the open floor are swallowed.
                clear = cur_floor;
                if (door_done) begin
                    timer_n = '0;
                    if (dir_up ? above : below) begin
                        state_n = dir_up ? MOVE_UP : MOVE_DOWN;
                    end else if (dir_up ? below : above) begin
                        state_n = dir_up ? MOVE_DOWN : MOVE_UP;
                        dir_n   = ~dir_up;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    timer_n = timer + 1'b1;
                end
            end

            default: begin
                state_n = IDLE;
                timer_n = '0;
            end
        endcase

        pend_n = (pending | req_in) & ~clear;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cur_floor   <= 8'h01;
            pending     <= '0;
            timer       <= '0;
            dir_up      <= 1'b1;
            moving_up   <= 1'b0;
            moving_down <= 1'b0;
            door_open   <= 1'b0;
            arrive      <= 1'b0;
        end else begin
            state       <= state_n;
            cur_floor   <= cur_n;
            pending     <= pend_n;
            timer       <= timer_n;
            dir_up      <= dir_n;
            moving_up   <= (state_n == MOVE_UP);
            moving_down <= (state_n == MOVE_DOWN);
            door_open   <= (state_n == DOOR);
            arrive      <= arrive_n;
        end
    end

endmodule

// File: tb/tb_elevator_scheduler.sv
// tb_elevator_scheduler: directed table, hand-written corner sequences
// and a randomized run against a floor-number reference model.
module tb_elevator_scheduler;

    localparam int STEP = 4;
    localparam int DOOR = 3;

    logic       clk;
    logic       rst_n;
    logic [7:0] req_in;
    logic [7:0] cur_floor;
    logic [7:0] pending;
    logic       moving_up;
    logic       moving_down;
    logic       door_open;
    logic       arrive;

    elevator_scheduler #(
        .STEP_CYCLES(STEP),
        .DOOR_CYCLES(DOOR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_in     (req_in),
        .cur_floor  (cur_floor),
        .pending    (pending),
        .moving_up  (moving_up),
        .moving_down(moving_down),
        .door_open  (door_open),
        .arrive     (arrive)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum int {M_IDLE, M_UP, M_DOWN, M_DOOR} mmode_e;
    mmode_e   m_mode;
    int       m_floor;
    bit [7:0] m_req;
    int       m_left;
    bit       m_dir_up;
    bit       m_arrive;

    function automatic bit any_above(bit [7:0] r, int f);
        for (int i = f + 1; i < 8; i++) if (r[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit any_below(bit [7:0] r, int f);
        for (int i = 0; i < f; i++) if (r[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step(input bit rst, input bit [7:0] req);
        bit [7:0] nreq;
        bit       ab;
        bit       bl;
        nreq     = m_req | req;
        m_arrive = 1'b0;
        ab       = any_above(m_req, m_floor);
        bl       = any_below(m_req, m_floor);
        if (!rst) begin
            m_mode   = M_IDLE;
            m_floor  = 0;
            m_req    = '0;
            m_left   = 0;
            m_dir_up = 1'b1;
            return;
        end
        case (m_mode)
            M_IDLE: begin
                if (m_req[m_floor]) begin
                    m_mode         = M_DOOR;
                    m_left         = DOOR;
                    m_arrive       = 1'b1;
                    m_dir_up       = 1'b1;
                    nreq[m_floor]  = 1'b0;
                end else if (ab) begin
                    m_mode   = M_UP;
                    m_left   = STEP;
                    m_dir_up = 1'b1;
                end else if (bl) begin
                    m_mode   = M_DOWN;
                    m_left   = STEP;
                    m_dir_up = 1'b0;
                end
            end
            M_UP, M_DOWN: begin
                m_left--;
                if (m_left == 0) begin
                    m_floor += (m_mode == M_UP) ? 1 : -1;
                    if (m_req[m_floor]) begin
                        m_mode        = M_DOOR;
                        m_left        = DOOR;
                        m_arrive      = 1'b1;
                        nreq[m_floor] = 1'b0;
                    end else begin
                        m_left = STEP;
                    end
                end
            end
            M_DOOR: begin
                nreq[m_floor] = 1'b0;
                m_left--;
                if (m_left == 0) begin
                    if (m_dir_up ? ab : bl) begin
                        m_mode = m_dir_up ? M_UP : M_DOWN;
                        m_left = STEP;
                    end else if (m_dir_up ? bl : ab) begin
                        m_dir_up = ~m_dir_up;
                        m_mode   = m_dir_up ? M_UP : M_DOWN;
                        m_left   = STEP;
                    end else begin
                        m_mode = M_IDLE;
                    end
                end
            end
            default: m_mode = M_IDLE;
        endcase
        m_req = nreq;
    endtask

    function automatic logic [19:0] model_vec();
        logic [7:0] f;
        f = 8'h01 << m_floor;
        return {f, m_req, m_mode == M_UP, m_mode == M_DOWN,
                m_mode == M_DOOR, m_arrive};
    endfunction

    function automatic logic [19:0] dut_vec();
        return {cur_floor, pending, moving_up, moving_down,
                door_open, arrive};
    endfunction

    // One clock: drive, edge, advance model, sample 1 time unit later.
    task automatic tick(input logic [7:0] req);
        req_in = req;
        @(posedge clk);
        model_step(rst_n, req);
        #1;
    endtask

    // ---------------- directed helpers ----------------
    logic [7:0] stops[$];
    int         steps;

    // Press req once, then run until idle with nothing pending.
    task automatic go(input string name, input logic [7:0] req,
                      input int limit);
        logic [7:0] prev;
        bit         done;
        stops.delete();
        steps = 0;
        done  = 1'b0;
        prev  = cur_floor;
        tick(req);
        for (int i = 0; i < limit && !done; i++) begin
            tick(8'h00);
            chk({name, " onehot"}, 32'($onehot(cur_floor)), 32'd1);
            if (cur_floor != prev) steps++;
            prev = cur_floor;
            if (arrive) stops.push_back(cur_floor);
            if (!moving_up && !moving_down && !door_open &&
                pending == 8'h00)
                done = 1'b1;
        end
        if (!done) chk({name, " timeout"}, 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [7:0] req;
        logic [7:0] cur;
        logic [7:0] pend;
        logic [3:0] flg;
    } vec_t;
    vec_t tbl[17];

    task automatic set_vec(input int i, input logic [7:0] r,
                           input logic [7:0] c, input logic [7:0] p,
                           input logic [3:0] f);
        tbl[i].req  = r;
        tbl[i].cur  = c;
        tbl[i].pend = p;
        tbl[i].flg  = f;
    endtask

    initial begin
        logic [7:0] r;
        int         moved;

        // flags = {moving_up, moving_down, door_open, arrive}
        set_vec(0, 8'h08, 8'h01, 8'h08, 4'b0000);
        set_vec(1, 8'h00, 8'h01, 8'h08, 4'b1000);
        set_vec(2, 8'h00, 8'h01, 8'h08, 4'b1000);
        set_vec(3, 8'h00, 8'h01, 8'h08, 4'b1000);
        set_vec(4, 8'h00, 8'h01, 8'h08, 4'b1000);
        set_vec(5, 8'h00, 8'h02, 8'h08, 4'b1000);
        set_vec(6, 8'h00, 8'h02, 8'h08, 4'b1000);
        set_vec(7, 8'h00, 8'h02, 8'h08, 4'b1000);
        set_vec(8, 8'h00, 8'h02, 8'h08, 4'b1000);
        set_vec(9, 8'h00, 8'h04, 8'h08, 4'b1000);
        set_vec(10, 8'h00, 8'h04, 8'h08, 4'b1000);
        set_vec(11, 8'h00, 8'h04, 8'h08, 4'b1000);
        set_vec(12, 8'h00, 8'h04, 8'h08, 4'b1000);
        set_vec(13, 8'h00, 8'h08, 8'h00, 4'b0011);
        set_vec(14, 8'h00, 8'h08, 8'h00, 4'b0010);
        set_vec(15, 8'h00, 8'h08, 8'h00, 4'b0010);
        set_vec(16, 8'h00, 8'h08, 8'h00, 4'b0000);

        // 1: reset with every button held
        rst_n  = 1'b0;
        req_in = 8'hFF;
        for (int i = 0; i < 3; i++) tick(8'hFF);
        chk("reset vec", 32'(dut_vec()), 32'({8'h01, 8'h00, 4'b0000}));
        rst_n = 1'b1;
        tick(8'hFF);
        chk("post-reset pending", 32'(pending), 32'h0000_00FF);
        chk("post-reset floor", 32'(cur_floor), 32'h0000_0001);
        rst_n = 1'b0;
        tick(8'h00);
        tick(8'h00);
        rst_n = 1'b1;

        // 2: floor 1 -> floor 4, cycle by cycle
        for (int i = 0; i < 17; i++) begin
            tick(tbl[i].req);
            chk($sformatf("tbl[%0d]", i), 32'(dut_vec()),
                32'({tbl[i].cur, tbl[i].pend, tbl[i].flg}));
        end

        // 3: call at the current floor, presses during the dwell
        go("to3", 8'h04, 60);
        chk("at floor3", 32'(cur_floor), 32'h0000_0004);
        tick(8'h04);
        tick(8'h00);
        chk("door no move", 32'(dut_vec()),
            32'({8'h04, 8'h00, 4'b0011}));
        tick(8'h04);
        chk("press in door 1", 32'(pending), 32'd0);
        tick(8'h04);
        chk("press in door 2", 32'({pending, door_open}),
            32'({8'h00, 1'b1}));
        tick(8'h00);
        chk("door over", 32'(dut_vec()), 32'({8'h04, 8'h00, 4'b0000}));

        // 4: SCAN ordering with calls added mid-sweep
        stops.delete();
        tick(8'h20);
        tick(8'h00);
        chk("scan moving up", 32'(moving_up), 32'd1);
        tick(8'h12);
        begin
            bit done;
            done = 1'b0;
            for (int i = 0; i < 120 && !done; i++) begin
                tick(8'h00);
                if (arrive) stops.push_back(cur_floor);
                if (dut_vec() == {cur_floor, 8'h00, 4'b0000})
                    done = 1'b1;
            end
            chk("scan done", 32'(done), 32'd1);
        end
        chk("scan nstops", 32'(stops.size()), 32'd3);
        if (stops.size() == 3) begin
            chk("scan stop0", 32'(stops[0]), 32'h10);
            chk("scan stop1", 32'(stops[1]), 32'h20);
            chk("scan stop2", 32'(stops[2]), 32'h02);
        end
        chk("scan pending", 32'(pending), 32'd0);

        // 5: full-height travel both ways
        go("to1", 8'h01, 60);
        chk("at floor1", 32'(cur_floor), 32'h01);
        go("up7", 8'h80, 80);
        chk("up steps", 32'(steps), 32'd7);
        chk("up stop", 32'(cur_floor), 32'h80);
        go("dn7", 8'h01, 80);
        chk("dn steps", 32'(steps), 32'd7);
        chk("dn stop", 32'(cur_floor), 32'h01);

        // 6: reset in the middle of a step
        go("to3b", 8'h04, 60);
        tick(8'h10);
        tick(8'h00);
        tick(8'h00);
        chk("mid-step moving", 32'({cur_floor, moving_up}),
            32'({8'h04, 1'b1}));
        rst_n = 1'b0;
        tick(8'h00);
        chk("mid reset", 32'(dut_vec()), 32'({8'h01, 8'h00, 4'b0000}));
        rst_n = 1'b1;
        moved = 0;
        for (int i = 0; i < 20; i++) begin
            tick(8'h00);
            if (dut_vec() != {8'h01, 8'h00, 4'b0000}) moved++;
        end
        chk("no motion after reset", 32'(moved), 32'd0);

        // Randomized run against the model
        rst_n = 1'b0;
        tick(8'h00);
        rst_n = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 499) != 0);
            if ($urandom_range(0, 11) == 0)
                r = 8'h01 << $urandom_range(0, 7);
            else if ($urandom_range(0, 99) == 0)
                r = 8'($urandom);
            else
                r = 8'h00;
            tick(r);
            chk($sformatf("rand[%0d]", i), 32'(dut_vec()),
                32'(model_vec()));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
